clock_counter_multi: RTL and testbench

- Multi-channel frequency meter in a single clock domain.
- Counts rising edges on NUM_CHANNELS asynchronous input signals over a programmable gate window of i_clk cycles.
- Supports one-shot and gapless continuous measurement, with per-channel saturation flags.
- Sits beside the AXI-attached clock monitors. Software derives each channel's frequency as f_clk * count / window.

---
 rtl/clock_counter_multi.sv | 206 ++++++++++++++++++++
 tb/tb_clock_counter_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_counter_multi.sv
// clock_counter_multi
// Multi-channel frequency meter. Each input is synchronised into i_clk, its
// rising edges are counted over a gate window of W i_clk cycles, and the
// per-channel counts are latched into o_counts when the window closes.
// Software derives frequency as f_clk * count / window.
//
// Handshake / control semantics (single-cycle level sampling, no ready path):
//   i_start is accepted only in IDLE and only when i_abort is low; the window
//   opens on the following cycle and o_busy is high for exactly W cycles
//   (W = i_window_cycles, with 0 treated as 1). On the last window cycle the
//   results load, o_done pulses for one cycle and o_valid rises. If
//   i_continuous is high on that last cycle a new window starts immediately
//   with a freshly sampled i_window_cycles. i_abort always wins: it closes the
//   window without loading results and without o_done.
//
// SYNC_STAGES must be at least 2.
module clock_counter_multi #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_WIDTH  = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [NUM_CHANNELS-1:0]               i_signals,
  input  logic [WINDOW_WIDTH-1:0]               i_window_cycles,
  input  logic                                  i_start,
  input  logic                                  i_continuous,
  input  logic                                  i_abort,
  output logic                                  o_busy,
  output logic                                  o_valid,
  output logic                                  o_done,
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] o_counts,
  output logic [NUM_CHANNELS-1:0]               o_overflow
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Synchroniser chain; index SYNC_STAGES-1 is the settled value.
  logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] prev_q;
  logic [NUM_CHANNELS-1:0] sig_edge;

  // Window bookkeeping: cycles left after the current one.
  logic [WINDOW_WIDTH-1:0] remaining_q;
  logic [WINDOW_WIDTH-1:0] window_reload;
  logic                    last_cycle;

  // Control strobes decoded from the FSM.
  logic start_ok;
  logic window_end;
  logic count_en;
  logic abort_meas;
  logic clear_cnt;

  logic valid_q;
  logic done_q;

  // Shift each input through the synchroniser and keep the previous settled value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= i_signals;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // A zero-length request still gives a one-cycle window.
  assign window_reload = (i_window_cycles == '0) ? '0
                                                 : i_window_cycles - WINDOW_WIDTH'(1);
  assign last_cycle    = (remaining_q == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes; abort takes priority over everything.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    window_end = 1'b0;
    count_en   = 1'b0;
    abort_meas = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d  = S_MEASURE;
          start_ok = 1'b1;
        end
      end
      S_MEASURE: begin
        if (i_abort) begin
          state_d    = S_IDLE;
          abort_meas = 1'b1;
        end else if (last_cycle) begin
          window_end = 1'b1;
          if (!i_continuous) begin
            state_d = S_IDLE;
          end
        end else begin
          count_en = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters restart at every window boundary and whenever a window is cancelled.
  assign clear_cnt = start_ok | window_end | abort_meas;

  // Load the window length at each window start, count it down otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      remaining_q <= '0;
    end else if (start_ok || (window_end && i_continuous)) begin
      remaining_q <= window_reload;
    end else if (count_en) begin
      remaining_q <= remaining_q - WINDOW_WIDTH'(1);
    end
  end

  // o_valid drops on an accepted start and rises when results load; abort leaves it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= window_end;
      if (start_ok) begin
        valid_q <= 1'b0;
      end else if (window_end) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign o_busy  = (state_q == S_MEASURE);
  assign o_valid = valid_q;
  assign o_done  = done_q;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_next;
    logic [COUNTER_WIDTH-1:0] res_q;
    logic                     sticky_q;
    logic                     ovf_q;
    logic                     cnt_full;
    logic                     ovf_hit;

    // Saturating increment: an edge on a full counter raises the overflow flag instead.
    assign cnt_full = &cnt_q;
    assign ovf_hit  = sig_edge[g] & cnt_full;
    assign cnt_next = (sig_edge[g] && !cnt_full) ? cnt_q + COUNTER_WIDTH'(1) : cnt_q;

    // Running count and sticky overflow for the open window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (clear_cnt) begin
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (count_en) begin
        cnt_q    <= cnt_next;
        sticky_q <= sticky_q | ovf_hit;
      end
    end

    // Latch the result including the last cycle's edge so no edge is lost at a boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        res_q <= '0;
        ovf_q <= 1'b0;
      end else if (window_end) begin
        res_q <= cnt_next;
        ovf_q <= sticky_q | ovf_hit;
      end
    end

    assign o_counts[g*COUNTER_WIDTH +: COUNTER_WIDTH] = res_q;
    assign o_overflow[g]                              = ovf_q;
  end

endmodule

// File: tb/tb_clock_counter_multi.sv
// tb_clock_counter_multi
// Drives two meters (32-bit and 4-bit counters) with identical stimulus and
// checks both against a window-level model every cycle, plus directed
// literal expectations for the interesting scenarios.
module tb_clock_counter_multi;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int CWS = 4;
  localparam int WW  = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUT wiring
  logic [NCH-1:0]     i_signals;
  logic [WW-1:0]      i_window_cycles;
  logic               i_start;
  logic               i_continuous;
  logic               i_abort;

  logic               o_busy,   o_valid,   o_done;
  logic [NCH*CW-1:0]  o_counts;
  logic [NCH-1:0]     o_overflow;
  logic               s_busy,   s_valid,   s_done;
  logic [NCH*CWS-1:0] s_counts;
  logic [NCH-1:0]     s_overflow;

  clock_counter_multi #(
    .NUM_CHANNELS(NCH), .COUNTER_WIDTH(CW), .WINDOW_WIDTH(WW), .SYNC_STAGES(2)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_signals(i_signals),
    .i_window_cycles(i_window_cycles), .i_start(i_start),
    .i_continuous(i_continuous), .i_abort(i_abort),
    .o_busy(o_busy), .o_valid(o_valid), .o_done(o_done),
    .o_counts(o_counts), .o_overflow(o_overflow)
  );

  clock_counter_multi #(
    .NUM_CHANNELS(NCH), .COUNTER_WIDTH(CWS), .WINDOW_WIDTH(WW), .SYNC_STAGES(2)
  ) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_signals(i_signals),
    .i_window_cycles(i_window_cycles), .i_start(i_start),
    .i_continuous(i_continuous), .i_abort(i_abort),
    .o_busy(s_busy), .o_valid(s_valid), .o_done(s_done),
    .o_counts(s_counts), .o_overflow(s_overflow)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int done_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- signal driver
  // Each channel is a square wave of the given period in i_clk cycles (0 = held low).
  int sig_period [NCH];
  int tick = 0;

  initial begin
    i_signals = '0;
    for (int c = 0; c < NCH; c++) sig_period[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      tick++;
      for (int c = 0; c < NCH; c++) begin
        if (sig_period[c] == 0) i_signals[c] = 1'b0;
        else                    i_signals[c] = ((tick % sig_period[c]) < (sig_period[c] / 2));
      end
    end
  end

  // ---------------------------------------------------------------- model
  // Window-level model: pin samples are kept as history; a rise between two
  // pin samples is credited to the counter three cycles later. Counts are
  // accumulated unbounded and clipped to each counter width at window end.
  logic [NCH-1:0]         hist [3];
  longint                 acc  [NCH];
  longint                 m_left;
  bit                     m_busy, m_valid, m_done;
  logic [NCH-1:0][CW-1:0] m_cnt_big;
  logic [NCH-1:0][CWS-1:0] m_cnt_small;
  logic [NCH-1:0]         m_ovf_big, m_ovf_small;
  logic [NCH*CW-1:0]      exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    logic [NCH-1:0] e;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      for (int c = 0; c < NCH; c++) acc[c] = 0;
      m_left = 0; m_busy = 0; m_valid = 0; m_done = 0;
      m_cnt_big = '0; m_cnt_small = '0; m_ovf_big = '0; m_ovf_small = '0;
    end else begin
      e = hist[1] & ~hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = i_signals;
      m_done  = 0;
      if (!m_busy) begin
        if (i_start && !i_abort) begin
          m_busy  = 1;
          m_valid = 0;
          m_left  = (i_window_cycles == 0) ? 1 : longint'(i_window_cycles);
          for (int c = 0; c < NCH; c++) acc[c] = 0;
        end
      end else if (i_abort) begin
        m_busy = 0;
        for (int c = 0; c < NCH; c++) acc[c] = 0;
      end else begin
        for (int c = 0; c < NCH; c++) acc[c] += longint'(e[c]);
        m_left--;
        if (m_left == 0) begin
          for (int c = 0; c < NCH; c++) begin
            m_cnt_big[c]   = (acc[c] > 64'hFFFF_FFFF) ? '1 : CW'(acc[c]);
            m_ovf_big[c]   = (acc[c] > 64'hFFFF_FFFF);
            m_cnt_small[c] = (acc[c] > 15) ? 4'hF : CWS'(acc[c]);
            m_ovf_small[c] = (acc[c] > 15);
            acc[c] = 0;
          end
          m_valid = 1;
          m_done  = 1;
          exp_q.push_back(m_cnt_big);
          if (i_continuous) m_left = (i_window_cycles == 0) ? 1 : longint'(i_window_cycles);
          else              m_busy = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",       o_busy,     m_busy);
      check("valid",      o_valid,    m_valid);
      check("done",       o_done,     m_done);
      check("counts",     o_counts,   m_cnt_big);
      check("overflow",   o_overflow, m_ovf_big);
      check("s_busy",     s_busy,     m_busy);
      check("s_valid",    s_valid,    m_valid);
      check("s_done",     s_done,     m_done);
      check("s_counts",   s_counts,   m_cnt_small);
      check("s_overflow", s_overflow, m_ovf_small);
      if (o_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: o_done with no expected result at %0t", $time);
        end else begin
          check("sb_counts", o_counts, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [WW-1:0] w, input logic cont);
    i_window_cycles = w;
    i_continuous    = cont;
    i_start         = 1'b1;
    step();
    i_start         = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!o_done && waited < budget);
    if (!o_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: no o_done within %0d cycles at %0t", budget, $time);
    end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    int waited;
    int sum;
    int lat;
    int done_before;
    logic [NCH*CW-1:0] prior_counts;
    logic [CW-1:0]     v;

    rst_n = 1'b1;
    i_window_cycles = '0;
    i_start = 1'b0;
    i_continuous = 1'b0;
    i_abort = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_busy",   o_busy,   0);
    check("rst_valid",  o_valid,  0);
    check("rst_counts", o_counts, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // One-shot W=1000: ch0 toggles every cycle, ch1 held low.
    sig_period[0] = 2; sig_period[1] = 0; sig_period[2] = 6; sig_period[3] = 10;
    repeat (10) step();
    done_before = done_seen;
    do_start(1000, 1'b0);
    wait_done(1100, waited);
    check("t1_latency", waited, 1001);
    v = o_counts[0*CW +: CW];
    check("t1_ch0_500", (v >= 499 && v <= 501), 1);
    check("t1_ch1_zero", o_counts[1*CW +: CW], 0);
    check("t1_busy_falls", o_busy, 0);
    check("t1_valid", o_valid, 1);
    check("t1_small_ch0_sat", s_counts[0*CWS +: CWS], 4'hF);
    repeat (5) @(negedge clk);
    check("t1_one_done", done_seen - done_before, 1);

    // Continuous W=100, ch0 period 4: 25 per window, back-to-back.
    sig_period[0] = 4;
    repeat (10) step();
    sum = 0;
    do_start(100, 1'b1);
    for (int w = 0; w < 10; w++) begin
      wait_done(120, waited);
      if (w > 0) check("t2_interval", waited, 100);
      check("t2_win25", o_counts[0*CW +: CW], 25);
      check("t2_valid_held", o_valid, 1);
      sum += int'(o_counts[0*CW +: CW]);
    end
    check("t2_sum250", sum, 250);
    i_continuous = 1'b0;
    wait_done(120, waited);
    check("t2_stop_busy", o_busy, 0);

    // Narrow counter: ch2 period 2 over W=64 saturates the 4-bit meter.
    sig_period[0] = 0; sig_period[1] = 0; sig_period[2] = 2; sig_period[3] = 10;
    repeat (10) step();
    do_start(64, 1'b0);
    wait_done(80, waited);
    check("t3_small_ch2", s_counts[2*CWS +: CWS], 4'hF);
    check("t3_small_ovf", s_overflow, 4'b0100);
    check("t3_big_ch2", o_counts[2*CW +: CW], 32);
    check("t3_big_ovf", o_overflow, 4'b0000);

    // Abort at cycle 50 of a W=100 one-shot.
    prior_counts = o_counts;
    step();
    do_start(100, 1'b0);
    repeat (49) @(posedge clk);
    #1 i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    @(negedge clk);
    check("t4_busy_drop", o_busy, 0);
    done_before = done_seen;
    repeat (70) @(negedge clk);
    check("t4_no_done", done_seen - done_before, 0);
    check("t4_valid_low", o_valid, 0);
    check("t4_counts_kept", o_counts, prior_counts);
    step();
    do_start(10, 1'b0);
    wait_done(20, waited);
    check("t4_restart_ch2", o_counts[2*CW +: CW], 5);

    // W=0 behaves as a one-cycle window.
    step();
    do_start(0, 1'b0);
    @(negedge clk);
    check("t5_busy", o_busy, 1);
    check("t5_not_done_yet", o_done, 0);
    @(negedge clk);
    check("t5_done", o_done, 1);
    check("t5_busy_fall", o_busy, 0);

    // Start pulsed while busy is ignored.
    step();
    do_start(20, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        i_window_cycles = 200;
        i_start = 1'b1;
      end
      if (lat == 6) i_start = 1'b0;
    end while (!o_done && lat < 300);
    check("t6_len_unchanged", lat, 21);

    // Start and abort together: stays idle.
    step();
    done_before = done_seen;
    i_window_cycles = 10;
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    @(negedge clk);
    check("t7_idle", o_busy, 0);
    repeat (15) @(negedge clk);
    check("t7_no_done", done_seen - done_before, 0);

    // Asynchronous reset mid-window in continuous mode.
    sig_period[0] = 2;
    step();
    do_start(30, 1'b1);
    repeat (45) @(posedge clk);
    #1;
    check("t8_valid_before", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_busy",     o_busy,     0);
    check("t8_valid",    o_valid,    0);
    check("t8_done",     o_done,     0);
    check("t8_counts",   o_counts,   0);
    check("t8_overflow", o_overflow, 0);
    check("t8_s_counts", s_counts,   0);
    i_continuous = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
